// File: rtl/sram_port_arbiter.sv
// -----------------------------------------------------------------------------
// sram_port_arbiter
//
// Shares the single-port synchronous image SRAM between three requesters:
//   0 = SRAM loader/reader feeding the CPU
//   1 = DWT engine
//   2 = tier-1 coefficient fetcher
//
// Arbitration is round-robin in IDLE. The owner may issue one access per cycle
// for as long as it keeps req high. When the burst count reaches MAX_BURST and
// another requester is waiting, the owner is cut off after that access. Every
// change of ownership passes through one dead TURN cycle and one IDLE cycle.
// Read data comes back one cycle after the read access and is tagged to the
// requester that issued it through rvalid.
//
// Ports
//   clk                    system clock, rising edge
//   rst                    asynchronous, active-low reset
//   req[2:0]               per-requester request level
//   we[2:0]                per-requester write enable, sampled with req
//   addr0/addr1/addr2      per-requester address
//   wdata0/wdata1/wdata2   per-requester write data
//   ack[2:0]               access accepted this cycle (one-hot or zero)
//   rvalid[2:0]            read data on rdata belongs to requester i
//   rdata                  read data, shared by all requesters
//   owner[1:0]             current owner index, 3 = none
//   sram_cs_n              SRAM chip select, active low
//   sram_we_n              SRAM write enable, active low
//   sram_addr              SRAM address
//   sram_wdata             SRAM write data
//   sram_rdata             SRAM read data, valid the cycle after a read
// -----------------------------------------------------------------------------
module sram_port_arbiter #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16,
  parameter int MAX_BURST = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        req,
  input  logic [2:0]        we,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [ADDR_W-1:0] addr2,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  input  logic [DATA_W-1:0] wdata2,
  output logic [2:0]        ack,
  output logic [2:0]        rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic [1:0]        owner,
  output logic              sram_cs_n,
  output logic              sram_we_n,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata
);

  // Counter wide enough to hold MAX_BURST itself (it saturates there).
  localparam int               CNT_W   = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);
  localparam logic [1:0]       NO_OWNER = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_OWN  = 2'd1,
    S_TURN = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------

  // Next requester index, wrapping 2 -> 0.
  function automatic logic [1:0] f_inc3(input logic [1:0] idx);
    logic [1:0] res;
    case (idx)
      2'd0:    res = 2'd1;
      2'd1:    res = 2'd2;
      default: res = 2'd0;
    endcase
    return res;
  endfunction

  // One-hot of a requester index; index 3 (no owner) maps to zero.
  function automatic logic [2:0] f_onehot(input logic [1:0] idx);
    logic [2:0] res;
    case (idx)
      2'd0:    res = 3'b001;
      2'd1:    res = 3'b010;
      2'd2:    res = 3'b100;
      default: res = 3'b000;
    endcase
    return res;
  endfunction

  // First requester with req set, searching ptr, ptr+1, ptr+2 (mod 3).
  function automatic logic [1:0] f_pick(input logic [2:0] rq, input logic [1:0] ptr);
    logic [1:0] p0;
    logic [1:0] p1;
    logic [1:0] p2;
    logic [1:0] res;
    p0 = ptr;
    p1 = f_inc3(p0);
    p2 = f_inc3(p1);
    if (|(rq & f_onehot(p0))) begin
      res = p0;
    end else if (|(rq & f_onehot(p1))) begin
      res = p1;
    end else begin
      res = p2;
    end
    return res;
  endfunction

  // ---------------------------------------------------------------------------
  // Registers and wires
  // ---------------------------------------------------------------------------
  state_t           r_state;
  state_t           w_state_next;
  logic [1:0]       r_owner;
  logic [1:0]       r_rr_ptr;
  logic [CNT_W-1:0] r_burst_cnt;
  logic [2:0]       r_rd_pend;

  logic [1:0]        w_pick;
  logic [2:0]        w_owner_oh;
  logic [2:0]        w_others;
  logic              w_own_req;
  logic              w_own_we;
  logic [ADDR_W-1:0] w_own_addr;
  logic [DATA_W-1:0] w_own_wdata;
  logic              w_access;
  logic [CNT_W-1:0]  w_cnt_inc;
  logic              w_cap;

  // Owner-side request/command multiplexer.
  always_comb begin
    w_own_req   = 1'b0;
    w_own_we    = 1'b0;
    w_own_addr  = {ADDR_W{1'b0}};
    w_own_wdata = {DATA_W{1'b0}};
    case (r_owner)
      2'd0: begin
        w_own_req   = req[0];
        w_own_we    = we[0];
        w_own_addr  = addr0;
        w_own_wdata = wdata0;
      end
      2'd1: begin
        w_own_req   = req[1];
        w_own_we    = we[1];
        w_own_addr  = addr1;
        w_own_wdata = wdata1;
      end
      2'd2: begin
        w_own_req   = req[2];
        w_own_we    = we[2];
        w_own_addr  = addr2;
        w_own_wdata = wdata2;
      end
      default: begin
        w_own_req   = 1'b0;
        w_own_we    = 1'b0;
        w_own_addr  = {ADDR_W{1'b0}};
        w_own_wdata = {DATA_W{1'b0}};
      end
    endcase
  end

  // Arbitration choice, access qualification and burst-cap detection.
  always_comb begin
    w_pick     = f_pick(req, r_rr_ptr);
    w_owner_oh = f_onehot(r_owner);
    w_others   = req & ~w_owner_oh;
    w_access   = (r_state == S_OWN) && w_own_req;
    if (r_burst_cnt == MAX_CNT) begin
      w_cnt_inc = r_burst_cnt;
    end else begin
      w_cnt_inc = r_burst_cnt + CNT_W'(1);
    end
    // Cut the owner off only when this access hits the cap and someone waits;
    // an uncontended owner keeps streaming with the counter parked at the cap.
    w_cap = w_access && (w_cnt_inc == MAX_CNT) && (|w_others);
  end

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (|req) begin
          w_state_next = S_OWN;
        end else begin
          w_state_next = S_IDLE;
        end
      end
      S_OWN: begin
        if (!w_own_req) begin
          w_state_next = S_TURN;
        end else if (w_cap) begin
          w_state_next = S_TURN;
        end else begin
          w_state_next = S_OWN;
        end
      end
      S_TURN: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Owner, round-robin pointer, burst counter and pending-read tag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_owner     <= NO_OWNER;
      r_rr_ptr    <= 2'd0;
      r_burst_cnt <= {CNT_W{1'b0}};
      r_rd_pend   <= 3'b000;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (|req) begin
            r_owner     <= w_pick;
            r_rr_ptr    <= f_inc3(w_pick);
            r_burst_cnt <= {CNT_W{1'b0}};
          end
        end
        S_OWN: begin
          if (w_access) begin
            r_burst_cnt <= w_cnt_inc;
          end
          // Ownership is given up as the port enters the dead cycle.
          if (w_state_next == S_TURN) begin
            r_owner <= NO_OWNER;
          end
        end
        S_TURN: begin
          r_owner <= NO_OWNER;
        end
        default: begin
          r_owner <= NO_OWNER;
        end
      endcase
      // A read issued this cycle returns next cycle, tagged to its issuer.
      if (w_access && !w_own_we) begin
        r_rd_pend <= w_owner_oh;
      end else begin
        r_rd_pend <= 3'b000;
      end
    end
  end

  // Output logic: SRAM pins are driven only during an access, parked otherwise.
  always_comb begin
    ack        = 3'b000;
    sram_cs_n  = 1'b1;
    sram_we_n  = 1'b1;
    sram_addr  = {ADDR_W{1'b0}};
    sram_wdata = {DATA_W{1'b0}};
    if (w_access) begin
      ack        = w_owner_oh;
      sram_cs_n  = 1'b0;
      sram_we_n  = ~w_own_we;
      sram_addr  = w_own_addr;
      sram_wdata = w_own_wdata;
    end else begin
      ack        = 3'b000;
      sram_cs_n  = 1'b1;
      sram_we_n  = 1'b1;
      sram_addr  = {ADDR_W{1'b0}};
      sram_wdata = {DATA_W{1'b0}};
    end
    rvalid = r_rd_pend;
    rdata  = sram_rdata;
    owner  = r_owner;
  end

endmodule

// File: doc/sram_port_arbiter.md
# sram_port_arbiter

Shares the single-port synchronous image SRAM between three requesters: the SRAM loader/reader feeding the CPU, the DWT engine and the tier-1 coefficient fetcher. It grants the port round-robin and lets the owner burst accesses until it releases or hits a burst cap. It inserts turnaround cycles between owners and routes 1-cycle-latency read data back to the requester that issued the read. It sits between the requesters and the SRAM pins, inside the serial JPEG2000 core.

## Interface
- ADDR_W, 16, SRAM address width
- DATA_W, 16, SRAM data width
- MAX_BURST, 16, max consecutive accesses per grant while another requester waits (≥1)

- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- req  in  3  per-requester request level, bit i = requester i (0 = loader, 1 = DWT, 2 = tier-1)
- we  in  3  per-requester write enable, sampled with req
- addr0/addr1/addr2  in  ADDR_W  per-requester address
- wdata0/wdata1/wdata2  in  DATA_W  per-requester write data
- ack  out  3  access accepted this cycle, one-hot or zero
- rvalid  out  3  read data valid on rdata for requester i, one-hot or zero
- rdata  out  DATA_W  read data, common to all requesters
- owner  out  2  current owner index, 3 = none
- sram_cs_n  out  1  SRAM chip select, active low
- sram_we_n  out  1  SRAM write enable, active low
- sram_addr  out  ADDR_W  SRAM address
- sram_wdata  out  DATA_W  SRAM write data
- sram_rdata  in  DATA_W  SRAM read data, valid the cycle after a read access

## Operation
- FSM states: IDLE, OWN, TURN. Registers: state, owner (2b), rr_ptr (2b, 0..2), burst_cnt, rd_pend (3b).
- IDLE: if any req bit is high, select the first requester with req set, searching rr_ptr, rr_ptr+1, rr_ptr+2 (mod 3). Load owner, set rr_ptr = owner+1 mod 3, clear burst_cnt, go to OWN. No access occurs in IDLE.
- OWN, req[owner]=1: access this cycle.
  - ack[owner]=1; sram_cs_n=0; sram_we_n=~we[owner]; sram_addr/sram_wdata = owner's addr/wdata (combinational mux).
  - burst_cnt increments, saturating at MAX_BURST.
- OWN, req[owner]=0: no access, go to TURN.
- OWN, access with burst_cnt reaching MAX_BURST and any other req bit high: this access completes, then go to TURN. If no other requester is waiting, stay in OWN; burst_cnt holds at MAX_BURST.
- TURN: one dead cycle with sram_cs_n=1. owner becomes 3, then go to IDLE.
- Read return: on a read access (ack[i]=1, we[i]=0), rd_pend = one-hot(i) for the next cycle. rvalid = rd_pend, and rdata = sram_rdata. Writes produce no rvalid.
- While sram_cs_n=1: sram_we_n=1, sram_addr=0, sram_wdata=0.
- Requesters must hold addr/we/wdata stable while req is high and ack is low. A requester may change them every cycle in which ack is high.
- Non-owner req bits are ignored until the next IDLE arbitration.

## Timing
- Reset values (async, rst=0): state=IDLE, owner=3, rr_ptr=0, burst_cnt=0, rd_pend=0.
  - Outputs: ack=0, rvalid=0, sram_cs_n=1, sram_we_n=1, sram_addr=0, sram_wdata=0.
  - rdata follows sram_rdata (don't-care when rvalid=0).
- Reset mid-burst: any in-flight read's rvalid is dropped. After rst deasserts, the first grant goes to the lowest-index requester.
- Grant latency: req rises in cycle N while in IDLE → owner loaded at N+1 edge → first ack in cycle N+1.
- Read latency: ack in cycle N with we=0 → rvalid with data in cycle N+1.
- Steady burst: one access per cycle.
- Owner switch cost: last access at cycle N, TURN at N+1, IDLE at N+2, new owner's first ack at N+3. The same cost applies when the owner drops req: drop at N (OWN) → TURN N+1 → IDLE N+2.
- Simultaneous requests in IDLE are resolved by rr_ptr only. No fixed priority.
- A read issued on the last access before TURN still returns its rvalid in the TURN cycle.

## Test plan
- Single read: reset, req=3'b001, we=0, addr0=0x0040 held one cycle after ack; SRAM model returns 0xBEEF.
  - Required: ack[0] in cycle 1 after req, sram_cs_n=0 with sram_addr=0x0040, rvalid=3'b001 with rdata=0xBEEF the next cycle, then TURN/IDLE with sram_cs_n=1.
- Round-robin: req=3'b111 held, bursts of 2 each (MAX_BURST=2).
  - Required: grant order 0,1,2,0.
  - Required: exactly 2 acks per grant, and 2 idle cycles (TURN, IDLE) between owners.
- Burst cap: req0 held for 40 accesses, req1 asserted at access 5, MAX_BURST=16.
  - Required: requester 0 gets 16 acks, then requester 1 is granted 3 cycles after the 16th ack.
- Uncontended burst: req0 alone for 40 cycles.
  - Required: 40 consecutive acks with no TURN cycle, and burst_cnt saturated at 16.
- Mixed read/write: requester 2 writes 0x1234 to 0x0100, then reads 0x0100 back to back.
  - Required: sram_we_n=0 then 1 on consecutive cycles.
  - Required: rvalid=3'b100 with rdata=0x1234 on the cycle after the read ack, and no rvalid for the write.
- Reset mid-read: assert rst in the cycle between a read ack and its rvalid.
  - Required: rvalid stays 0, all SRAM outputs go to reset values immediately, and after release req=3'b110 is granted to requester 1 first.
